// File: rtl/i2c_slave_ram_port.sv
// i2c_slave_ram_port: I2C slave giving a bus master write/read access to a 32x8 RAM
// Ports:
//    clk, reset        system clock, synchronous active-high reset
//    Slave_Enable      0 = ignore the bus, release sda, stay idle
//    scl_in, sda_in    raw bus levels (synchronised internally)
//    sda_drive_low     1 = pull sda low (open drain), 0 = release
//    RAM_Addr          shared remote-write / local-read address
//    RemoteRAM_DIN     received data byte
//    RemoteRAM_W       one-clk write strobe
//    LocalRAM_DOUT     RAM read data, valid one clk after RAM_Addr
//    busy              set while an addressed transfer is in progress
module i2c_slave_ram_port #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h42,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Slave_Enable,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_drive_low,
   output logic [4:0] RAM_Addr,
   output logic [7:0] RemoteRAM_DIN,
   output logic       RemoteRAM_W,
   input  logic [7:0] LocalRAM_DOUT,
   output logic       busy
);
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic                   r_scl_d, r_sda_d;
   logic [3:0]             r_bit_cnt;
   logic [7:0]             r_shift;
   logic [7:0]             r_din;
   logic [4:0]             r_addr;
   logic [1:0]             r_ld;
   logic                   r_rw, r_w, r_sda_low;
   logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_last, w_match;
   logic [7:0]             w_byte;

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
   assign w_byte     = {r_shift[6:0], w_sda};
   assign w_last     = r_bit_cnt == 4'd7;
   assign w_match    = w_byte[7:1] == SLAVE_ADDR;

   assign sda_drive_low = r_sda_low;
   assign RAM_Addr      = r_addr;
   assign RemoteRAM_DIN = r_din;
   assign RemoteRAM_W   = r_w;
   assign busy          = (r_state >= ADDR_ACK) && (r_state <= RDATA_ACK);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_bit_cnt <= 4'd0;
         r_shift   <= 8'd0;
         r_din     <= 8'd0;
         r_addr    <= 5'd0;
         r_ld      <= 2'd0;
         r_rw      <= 1'b0;
         r_w       <= 1'b0;
         r_sda_low <= 1'b0;
      end else begin
         r_w  <= 1'b0;
         // read-data fetch: RAM_Addr settles, RAM answers a clk later, then capture
         r_ld <= {r_ld[0], 1'b0};
         if (r_ld[1]) r_shift <= LocalRAM_DOUT;
         // post-increment after the strobe so the write used the old address
         if (r_w) r_addr <= r_addr + 5'd1;
         if (!Slave_Enable || w_stop) begin
            r_state   <= IDLE;
            r_sda_low <= 1'b0;
         end else if (w_start) begin
            r_state   <= ADDR;
            r_bit_cnt <= 4'd0;
            r_sda_low <= 1'b0;
         end else begin
            case (r_state)
               ADDR: if (w_scl_rise) begin
                  r_shift   <= w_byte;
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (w_last) begin
                     r_rw    <= w_sda;
                     r_state <= w_match ? ADDR_ACK : WAIT_STOP;
                     r_ld    <= {r_ld[0], w_sda & w_match};
                  end
               end
               PTR, WDATA: if (w_scl_rise) begin
                  r_shift   <= w_byte;
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (w_last) begin
                     r_state <= (r_state == PTR) ? PTR_ACK : WDATA_ACK;
                     if (r_state == PTR) r_addr <= w_byte[4:0];
                     else begin
                        r_din <= w_byte;
                        r_w   <= 1'b1;
                     end
                  end
               end
               // count 8: first falling edge, start ACK; count 9: falling edge after the ACK clock
               ADDR_ACK, PTR_ACK, WDATA_ACK: if (w_scl_fall) begin
                  if (r_bit_cnt == 4'd8) begin
                     r_sda_low <= 1'b1;
                     r_bit_cnt <= 4'd9;
                  end else if (r_state == ADDR_ACK && r_rw) begin
                     r_state   <= RDATA;
                     r_sda_low <= ~r_shift[7];
                     r_shift   <= {r_shift[6:0], 1'b1};
                     r_bit_cnt <= 4'd1;
                  end else begin
                     r_state   <= (r_state == ADDR_ACK) ? PTR : WDATA;
                     r_sda_low <= 1'b0;
                     r_bit_cnt <= 4'd0;
                  end
               end
               RDATA: if (w_scl_fall) begin
                  if (r_bit_cnt == 4'd8) begin
                     r_state   <= RDATA_ACK;
                     r_sda_low <= 1'b0;
                     r_bit_cnt <= 4'd0;
                  end else begin
                     r_sda_low <= ~r_shift[7];
                     r_shift   <= {r_shift[6:0], 1'b1};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
               RDATA_ACK: if (w_scl_rise) begin
                  if (w_sda) r_state <= WAIT_STOP;
                  else begin
                     r_bit_cnt <= 4'd9;
                     r_addr    <= r_addr + 5'd1;
                     r_ld      <= {r_ld[0], 1'b1};
                  end
               end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
                  r_state   <= RDATA;
                  r_sda_low <= ~r_shift[7];
                  r_shift   <= {r_shift[6:0], 1'b1};
                  r_bit_cnt <= 4'd1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_slave_ram_port.sv
// tb_i2c_slave_ram_port: directed bench driving an I2C master against the RAM port
module tb_i2c_slave_ram_port;
   localparam int Q = 8;

   typedef struct {
      logic [7:0] dev, ptr, d0, d1;
      logic [3:0] acks;
      int         nw;
      logic [4:0] a0, a1;
      logic [7:0] e0, e1;
      logic [4:0] end_addr;
      logic       bsy;
   } vec_t;

   logic       clk = 1'b0, reset = 1'b1, en = 1'b1, scl = 1'b1, sda_m = 1'b1;
   logic       sda_drive_low, RemoteRAM_W, busy, sda_line;
   logic [4:0] RAM_Addr;
   logic [7:0] RemoteRAM_DIN, dout;
   logic [7:0] ram [32];
   logic [4:0] wr_a [$];
   logic [7:0] wr_d [$];
   int         bcnt = 0, scnt = 0, n_pass = 0, n_tot = 0;

   assign sda_line = sda_m & ~sda_drive_low;

   i2c_slave_ram_port dut (
      .clk(clk), .reset(reset), .Slave_Enable(en), .scl_in(scl), .sda_in(sda_line),
      .sda_drive_low(sda_drive_low), .RAM_Addr(RAM_Addr), .RemoteRAM_DIN(RemoteRAM_DIN),
      .RemoteRAM_W(RemoteRAM_W), .LocalRAM_DOUT(dout), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) begin
      dout <= ram[RAM_Addr];
      if (RemoteRAM_W) ram[RAM_Addr] <= RemoteRAM_DIN;
   end

   always @(negedge clk) begin
      if (busy) bcnt++;
      if (sda_drive_low) scnt++;
      if (RemoteRAM_W) begin
         wr_a.push_back(RAM_Addr);
         wr_d.push_back(RemoteRAM_DIN);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_x(input logic d, output logic s);
      sda_m = d;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      s = sda_line;
      tick(Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic i2c_start;
      sda_m = 1'b1;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      sda_m = 1'b0;
      tick(Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      sda_m = 1'b1;
      tick(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_x(b[i], s);
      bit_x(1'b1, ack);
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_x(1'b1, s);
         b[i] = s;
      end
      bit_x(mack, s);
   endtask

   initial begin
      vec_t       v [5];
      logic [3:0] acks;
      logic [7:0] b0, b1;
      int         wb, bb, sb;
      v[0] = '{8'h84, 8'h03, 8'hA5, 8'h5A, 4'h0, 2, 5'd3,  5'd4, 8'hA5, 8'h5A, 5'd5, 1'b1};
      v[1] = '{8'h84, 8'h1F, 8'h11, 8'h22, 4'h0, 2, 5'd31, 5'd0, 8'h11, 8'h22, 5'd1, 1'b1};
      v[2] = '{8'h90, 8'h03, 8'h77, 8'h88, 4'hF, 0, 5'd0,  5'd0, 8'h00, 8'h00, 5'd1, 1'b0};
      v[3] = '{8'h84, 8'hE7, 8'h00, 8'hFF, 4'h0, 2, 5'd7,  5'd8, 8'h00, 8'hFF, 5'd9, 1'b1};
      v[4] = '{8'h84, 8'h05, 8'h3C, 8'hC3, 4'h0, 2, 5'd5,  5'd6, 8'h3C, 8'hC3, 5'd7, 1'b1};

      tick(4);
      reset = 1'b0;
      tick(1);
      chk("rst sda", 32'(sda_drive_low), 0);
      chk("rst w", 32'(RemoteRAM_W), 0);
      chk("rst din", 32'(RemoteRAM_DIN), 0);
      chk("rst addr", 32'(RAM_Addr), 0);
      chk("rst busy", 32'(busy), 0);

      for (int i = 0; i < 5; i++) begin
         wb = wr_a.size();
         bb = bcnt;
         sb = scnt;
         i2c_start();
         send_byte(v[i].dev, acks[3]);
         send_byte(v[i].ptr, acks[2]);
         send_byte(v[i].d0, acks[1]);
         send_byte(v[i].d1, acks[0]);
         i2c_stop();
         tick(4);
         chk($sformatf("v%0d acks", i), 32'(acks), 32'(v[i].acks));
         chk($sformatf("v%0d nwrites", i), 32'(wr_a.size() - wb), 32'(v[i].nw));
         if (wr_a.size() - wb >= 2) begin
            chk($sformatf("v%0d addr0", i), 32'(wr_a[wb]), 32'(v[i].a0));
            chk($sformatf("v%0d data0", i), 32'(wr_d[wb]), 32'(v[i].e0));
            chk($sformatf("v%0d addr1", i), 32'(wr_a[wb+1]), 32'(v[i].a1));
            chk($sformatf("v%0d data1", i), 32'(wr_d[wb+1]), 32'(v[i].e1));
         end
         chk($sformatf("v%0d end addr", i), 32'(RAM_Addr), 32'(v[i].end_addr));
         chk($sformatf("v%0d busy seen", i), 32'(bcnt != bb), 32'(v[i].bsy));
         chk($sformatf("v%0d sda seen", i), 32'(scnt != sb), 32'(v[i].bsy));
         chk($sformatf("v%0d busy after stop", i), 32'(busy), 0);
      end

      wb = wr_a.size();
      i2c_start();
      send_byte(8'h84, acks[2]);
      send_byte(8'h05, acks[1]);
      i2c_start();
      send_byte(8'h85, acks[0]);
      recv_byte(1'b0, b0);
      recv_byte(1'b1, b1);
      i2c_stop();
      tick(4);
      chk("rd acks", 32'(acks[2:0]), 0);
      chk("rd byte0", 32'(b0), 32'h3C);
      chk("rd byte1", 32'(b1), 32'hC3);
      chk("rd end addr", 32'(RAM_Addr), 6);
      chk("rd no write", 32'(wr_a.size() - wb), 0);

      wb = wr_a.size();
      i2c_start();
      send_byte(8'h84, acks[1]);
      send_byte(8'h02, acks[0]);
      for (int i = 0; i < 4; i++) bit_x(1'b1, b0[0]);
      chk("ab busy before", 32'(busy), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("ab sda", 32'(sda_drive_low), 0);
      chk("ab w", 32'(RemoteRAM_W), 0);
      chk("ab din", 32'(RemoteRAM_DIN), 0);
      chk("ab addr", 32'(RAM_Addr), 0);
      chk("ab busy", 32'(busy), 0);
      @(negedge clk);
      reset = 1'b0;
      i2c_stop();
      tick(4);
      chk("ab no write", 32'(wr_a.size() - wb), 0);
      wb = wr_a.size();
      i2c_start();
      send_byte(8'h84, acks[2]);
      send_byte(8'h0A, acks[1]);
      send_byte(8'h99, acks[0]);
      i2c_stop();
      tick(4);
      chk("post ab acks", 32'(acks[2:0]), 0);
      chk("post ab nwrites", 32'(wr_a.size() - wb), 1);
      if (wr_a.size() > wb) begin
         chk("post ab addr", 32'(wr_a[wb]), 10);
         chk("post ab data", 32'(wr_d[wb]), 32'h99);
      end
      chk("post ab end addr", 32'(RAM_Addr), 11);

      wb = wr_a.size();
      i2c_start();
      send_byte(8'h84, acks[2]);
      en = 1'b0;
      sb = scnt;
      send_byte(8'h06, acks[1]);
      send_byte(8'h55, acks[0]);
      i2c_stop();
      tick(4);
      chk("dis addr ack", 32'(acks[2]), 0);
      chk("dis later acks", 32'(acks[1:0]), 3);
      chk("dis no write", 32'(wr_a.size() - wb), 0);
      chk("dis no sda", 32'(scnt - sb), 0);
      chk("dis busy", 32'(busy), 0);
      en = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
